// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and general-purpose register file.
//   The EX/MEM->WB pipeline register feeding this block updates on the falling
//   edge, so every input is stable around the rising edge used here.
//
//   - wb_data_out selects load data for loads, otherwise the ALU result.
//   - A commit writes wb_data_out into regs[wb_addr_in] on the rising edge.
//   - Two combinational read ports with write-through bypass of the pending
//     commit, so decode sees the value landing on the next edge.
//   - Registered forwarding tap (fwd_*) describing the last commit.
//   - Saturating commit counter.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   alu_result_in  in   ALU result of the instruction in WB
//   ram_rdata_in   in   memory read data of the instruction in WB
//   gp_reg_wb_in   in   register-file write enable
//   mem_re_in      in   instruction was a load
//   wb_addr_in     in   destination register
//   rd_addr1/2     in   read port addresses
//   rd_data1/2     out  read port data (combinational)
//   wb_data_out    out  selected writeback value (combinational)
//   fwd_valid      out  a commit happened on the last rising edge
//   fwd_addr       out  address of the last commit (held otherwise)
//   fwd_data       out  data of the last commit (held otherwise)
//   commit_count   out  commits since reset, saturating
// ----------------------------------------------------------------------------
module wb_regfile #(
   parameter int DATA_W   = 10,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] ram_rdata_in,
   input  logic              gp_reg_wb_in,
   input  logic              mem_re_in,
   input  logic [ADDR_W-1:0] wb_addr_in,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic [DATA_W-1:0] wb_data_out,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  commit_count
);

   localparam int             DEPTH   = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_zero;
   logic              commit;
   logic              rd1_zero;
   logic              rd2_zero;

   assign wb_data_out = mem_re_in ? ram_rdata_in : alu_result_in;

   // reset is folded in so the bypass path cannot leak a write while the
   // block is held in reset; with gp_reg_wb_in=0 the AND forces commit to 0
   // even if the address or data inputs are X.
   assign wr_zero = ZERO_REG && (wb_addr_in == '0);
   assign commit  = gp_reg_wb_in & ~wr_zero & reset;

   assign rd1_zero = ZERO_REG && (rd_addr1 == '0);
   assign rd2_zero = ZERO_REG && (rd_addr2 == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (commit) begin
         regs[wb_addr_in] <= wb_data_out;
      end
   end

   // Each port resolves independently: hard zero, then bypass, then array.
   always_comb begin
      rd_data1 = regs[rd_addr1];
      if (commit && (rd_addr1 == wb_addr_in)) begin
         rd_data1 = wb_data_out;
      end
      if (rd1_zero) begin
         rd_data1 = '0;
      end
   end

   always_comb begin
      rd_data2 = regs[rd_addr2];
      if (commit && (rd_addr2 == wb_addr_in)) begin
         rd_data2 = wb_data_out;
      end
      if (rd2_zero) begin
         rd_data2 = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fwd_valid <= 1'b0;
         fwd_addr  <= '0;
         fwd_data  <= '0;
      end else begin
         fwd_valid <= commit;
         if (commit) begin
            fwd_addr <= wb_addr_in;
            fwd_data <= wb_data_out;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         commit_count <= '0;
      end else if (commit && (commit_count != CNT_MAX)) begin
         commit_count <= commit_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] alu_result_in;
   logic [9:0] ram_rdata_in;
   logic       gp_reg_wb_in;
   logic       mem_re_in;
   logic [2:0] wb_addr_in;
   logic [2:0] rd_addr1;
   logic [2:0] rd_addr2;

   logic [9:0]  rd_data1, rd_data2, wb_data_out, fwd_data;
   logic        fwd_valid;
   logic [2:0]  fwd_addr;
   logic [15:0] commit_count;

   logic [9:0] s_rd_data1, s_rd_data2, s_wb_data_out, s_fwd_data;
   logic       s_fwd_valid;
   logic [2:0] s_fwd_addr;
   logic [3:0] s_commit_count;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .reset(reset),
      .alu_result_in(alu_result_in), .ram_rdata_in(ram_rdata_in),
      .gp_reg_wb_in(gp_reg_wb_in), .mem_re_in(mem_re_in),
      .wb_addr_in(wb_addr_in), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2), .wb_data_out(wb_data_out),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
      .commit_count(commit_count)
   );

   wb_regfile #(.CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset),
      .alu_result_in(alu_result_in), .ram_rdata_in(ram_rdata_in),
      .gp_reg_wb_in(gp_reg_wb_in), .mem_re_in(mem_re_in),
      .wb_addr_in(wb_addr_in), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(s_rd_data1), .rd_data2(s_rd_data2), .wb_data_out(s_wb_data_out),
      .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data),
      .commit_count(s_commit_count)
   );

   typedef struct {
      logic        v;
      logic [2:0]  a;
      logic [9:0]  d;
      int unsigned cnt;
      int unsigned cnt4;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [9:0]  m_regs [8];
   logic [2:0]  m_fa;
   logic [9:0]  m_fd;
   int unsigned m_cnt;
   int unsigned m_cnt4;

   function automatic logic [9:0] sel_data();
      return mem_re_in ? ram_rdata_in : alu_result_in;
   endfunction

   function automatic logic cur_commit();
      return (gp_reg_wb_in === 1'b1) && (wb_addr_in != 3'd0) && (reset === 1'b1);
   endfunction

   function automatic logic [9:0] exp_read(input logic [2:0] a);
      if (a == 3'd0) return 10'd0;
      if (cur_commit() && a == wb_addr_in) return sel_data();
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 10'd0;
      m_fa = 3'd0; m_fd = 10'd0; m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic drive(input logic [9:0] alu, input logic [9:0] ram,
                        input logic mre, input logic wb, input logic [2:0] addr);
      @(negedge clk);
      alu_result_in = alu; ram_rdata_in = ram;
      mem_re_in = mre; gp_reg_wb_in = wb; wb_addr_in = addr;
      #1;
   endtask

   // Predicts the outcome of the coming rising edge, queues it, then steps.
   task automatic edge_push();
      exp_t e;
      logic c;
      c = cur_commit();
      if (c) begin
         m_regs[wb_addr_in] = sel_data();
         m_fa = wb_addr_in;
         m_fd = sel_data();
         if (m_cnt  < 65535) m_cnt++;
         if (m_cnt4 < 15)    m_cnt4++;
      end
      e.v = c; e.a = m_fa; e.d = m_fd; e.cnt = m_cnt; e.cnt4 = m_cnt4;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      alu_result_in = '0; ram_rdata_in = '0; mem_re_in = 0; gp_reg_wb_in = 1;
      wb_addr_in = 3'd4; rd_addr1 = 3'd4; rd_addr2 = 3'd0;
      model_reset();
      #3;
      for (int i = 0; i < 8; i++) begin
         rd_addr1 = 3'(i); #1;
         n_checks++;
         if (rd_data1 !== 10'd0) begin
            n_fail++; $display("FAIL reset_read addr=%0d got=%h exp=000", i, rd_data1);
         end
      end
      n_checks++;
      if ({fwd_valid, fwd_addr, fwd_data, commit_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got v=%b a=%h d=%h c=%0d exp all 0",
                  fwd_valid, fwd_addr, fwd_data, commit_count);
      end
      @(posedge clk); #1;
      n_checks++;
      if (commit_count !== 16'd0 || fwd_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold got c=%0d v=%b exp 0", commit_count, fwd_valid);
      end
      @(negedge clk);
      gp_reg_wb_in = 0;
      reset = 1'b1;
   endtask

   task automatic check_pop(input string name);
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s scoreboard_empty", name);
         return;
      end
      e = sb.pop_front();
      n_checks++;
      if (fwd_valid !== e.v || fwd_addr !== e.a || fwd_data !== e.d ||
          commit_count !== 16'(e.cnt) || s_commit_count !== 4'(e.cnt4)) begin
         n_fail++;
         $display("FAIL %s got v=%b a=%h d=%h c=%0d c4=%0d exp v=%b a=%h d=%h c=%0d c4=%0d",
                  name, fwd_valid, fwd_addr, fwd_data, commit_count, s_commit_count,
                  e.v, e.a, e.d, e.cnt, e.cnt4);
      end
   endtask

   task automatic test_alu_wb();
      drive(10'h155, 10'h000, 0, 1, 3'd3);
      edge_push();
      check_pop("alu_wb_fwd");
      n_checks++;
      if (fwd_valid !== 1'b1 || fwd_addr !== 3'd3 || fwd_data !== 10'h155 || commit_count !== 16'd1) begin
         n_fail++;
         $display("FAIL alu_wb_abs got v=%b a=%h d=%h c=%0d exp 1 3 155 1",
                  fwd_valid, fwd_addr, fwd_data, commit_count);
      end
      drive(10'h000, 10'h000, 0, 0, 3'd0);
      rd_addr1 = 3'd3; #1;
      n_checks++;
      if (rd_data1 !== 10'h155) begin
         n_fail++; $display("FAIL alu_wb_read got=%h exp=155", rd_data1);
      end
      edge_push();
      check_pop("alu_wb_idle");
   endtask

   task automatic test_load_select();
      drive(10'h0AA, 10'h3C3, 1, 1, 3'd5);
      n_checks++;
      if (wb_data_out !== 10'h3C3) begin
         n_fail++; $display("FAIL load_sel got=%h exp=3c3", wb_data_out);
      end
      edge_push();
      check_pop("load_fwd");
      drive(10'h0AA, 10'h3C3, 0, 0, 3'd5);
      n_checks++;
      if (wb_data_out !== 10'h0AA) begin
         n_fail++; $display("FAIL alu_sel got=%h exp=0aa", wb_data_out);
      end
      rd_addr1 = 3'd5; #1;
      n_checks++;
      if (rd_data1 !== 10'h3C3) begin
         n_fail++; $display("FAIL load_read got=%h exp=3c3", rd_data1);
      end
      edge_push();
      check_pop("load_idle");
   endtask

   task automatic test_bypass_r0();
      drive(10'h2F0, 10'h000, 0, 1, 3'd6);
      rd_addr1 = 3'd6; rd_addr2 = 3'd6; #1;
      n_checks++;
      if (rd_data1 !== 10'h2F0 || rd_data2 !== 10'h2F0) begin
         n_fail++; $display("FAIL bypass got p1=%h p2=%h exp=2f0", rd_data1, rd_data2);
      end
      edge_push();
      check_pop("bypass_fwd");
      drive(10'h3FF, 10'h000, 0, 1, 3'd0);
      rd_addr1 = 3'd0; rd_addr2 = 3'd6; #1;
      n_checks++;
      if (rd_data1 !== 10'd0 || rd_data2 !== 10'h2F0) begin
         n_fail++; $display("FAIL r0_read got p1=%h p2=%h exp 000 2f0", rd_data1, rd_data2);
      end
      edge_push();
      check_pop("r0_suppressed");
      n_checks++;
      if (fwd_valid !== 1'b0 || fwd_addr !== 3'd6 || fwd_data !== 10'h2F0) begin
         n_fail++; $display("FAIL r0_hold got v=%b a=%h d=%h exp 0 6 2f0", fwd_valid, fwd_addr, fwd_data);
      end
      drive(10'h000, 10'h000, 0, 0, 3'd0);
      n_checks++;
      if (rd_data1 !== 10'd0) begin
         n_fail++; $display("FAIL r0_after got=%h exp=000", rd_data1);
      end
   endtask

   task automatic test_no_write_load();
      for (int k = 0; k < 4; k++) begin
         if (k < 2) drive(10'h0F0, 10'h1E1, 1, 0, 3'd2);
         else       drive('x, 'x, 1'bx, 0, 3'bxxx);
         if (k < 2) begin
            n_checks++;
            if (wb_data_out !== 10'h1E1) begin
               n_fail++; $display("FAIL nowrite_sel got=%h exp=1e1", wb_data_out);
            end
         end
         edge_push();
         check_pop("nowrite_fwd");
      end
      drive(10'h000, 10'h000, 0, 0, 3'd0);
      for (int i = 1; i < 8; i++) begin
         rd_addr1 = 3'(i); #1;
         n_checks++;
         if (rd_data1 !== m_regs[i]) begin
            n_fail++; $display("FAIL nowrite_regs addr=%0d got=%h exp=%h", i, rd_data1, m_regs[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [9:0] e1, e2;
      for (int k = 0; k < 40; k++) begin
         drive(10'($urandom), 10'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
               3'($urandom));
         rd_addr1 = 3'($urandom);
         rd_addr2 = ($urandom_range(0, 3) == 0) ? wb_addr_in : 3'($urandom);
         #1;
         e1 = exp_read(rd_addr1);
         e2 = exp_read(rd_addr2);
         n_checks++;
         if (rd_data1 !== e1 || rd_data2 !== e2 || wb_data_out !== sel_data()) begin
            n_fail++;
            $display("FAIL rand_read k=%0d got p1=%h p2=%h wd=%h exp %h %h %h",
                     k, rd_data1, rd_data2, wb_data_out, e1, e2, sel_data());
         end
         edge_push();
         check_pop("rand_fwd");
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 20; k++) begin
         drive(10'(k + 1), 10'h000, 0, 1, 3'(1 + (k % 7)));
         edge_push();
         check_pop("sat_fwd");
      end
      n_checks++;
      if (s_commit_count !== 4'd15) begin
         n_fail++; $display("FAIL sat_final got=%0d exp=15", s_commit_count);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 1; i < 8; i++) begin
         drive(10'(i), 10'h000, 0, 1, 3'(i));
         edge_push();
         check_pop("fill_fwd");
      end
      drive(10'h000, 10'h000, 0, 0, 3'd0);
      rd_addr1 = 3'd7; #1;
      n_checks++;
      if (rd_data1 !== 10'h007) begin
         n_fail++; $display("FAIL fill_read got=%h exp=007", rd_data1);
      end
      gp_reg_wb_in = 1; wb_addr_in = 3'd3; alu_result_in = 10'h111;
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      for (int i = 0; i < 8; i++) begin
         rd_addr1 = 3'(i); rd_addr2 = 3'(7 - i); #1;
         n_checks++;
         if (rd_data1 !== 10'd0 || rd_data2 !== 10'd0) begin
            n_fail++; $display("FAIL areset_read addr=%0d got p1=%h p2=%h exp 000", i, rd_data1, rd_data2);
         end
      end
      n_checks++;
      if ({fwd_valid, fwd_addr, fwd_data, commit_count, s_commit_count} !== '0) begin
         n_fail++;
         $display("FAIL areset_state got v=%b a=%h d=%h c=%0d c4=%0d exp all 0",
                  fwd_valid, fwd_addr, fwd_data, commit_count, s_commit_count);
      end
      @(negedge clk);
      reset = 1'b1;
      alu_result_in = 10'h222; wb_addr_in = 3'd2; rd_addr1 = 3'd3;
      #1;
      edge_push();
      check_pop("post_reset_fwd");
      n_checks++;
      if (rd_data1 !== 10'd0) begin
         n_fail++; $display("FAIL post_reset_r3 got=%h exp=000", rd_data1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu_wb();
      test_load_select();
      test_bypass_r0();
      test_no_write_load();
      test_saturation();
      test_random();
      test_async_reset();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
